// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage core.
//
// Turns per-stage stall requests into a hold vector for the stage registers,
// converts an exception request into a one-cycle flush plus a registered
// redirect PC, runs a stall watchdog and optionally counts stalled cycles.
//
// Optional feature macro: PIPE_CTRL_PERF_EN (enables the stall_cycles counter;
// when undefined, stall_cycles is tied to 0).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   stallreq_id/ex/mem    per-stage hold requests (mem highest priority)
//   excp_req, excp_pc     exception/redirect request and handler address
//   stall[5:0]            hold vector: pc, if/id, id/ex, ex/mem, mem/wb, reserved
//   flush, new_pc         one-cycle flush and registered redirect address
//   busy                  FSM not in RUN
//   stall_timeout         sticky watchdog flag
//   stall_cycles          stalled-cycle counter (perf build only)
module pipe_ctrl #(
  parameter int unsigned STALL_LIMIT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             excp_req,
  input  logic [31:0]      excp_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             busy,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {StRun, StStall, StFlush, StDrain} state_e;

  localparam logic [15:0] Limit = 16'(STALL_LIMIT);

  state_e      state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [15:0] run_cnt_q, run_cnt_d, run_cnt_inc;
  logic        tmo_q, tmo_d;
  logic [5:0]  req_vec;
  logic        any_req;

  assign any_req = stallreq_id | stallreq_ex | stallreq_mem;

  // Highest requesting stage holds itself and everything upstream of it.
  always_comb begin
    req_vec = 6'b000000;
    if (stallreq_mem)     req_vec = 6'b011111;
    else if (stallreq_ex) req_vec = 6'b001111;
    else if (stallreq_id) req_vec = 6'b000111;
  end

  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    stall    = 6'b000000;
    flush    = 1'b0;
    unique case (state_q)
      StRun, StStall: begin
        stall = req_vec;
        if (excp_req) begin
          state_d  = StFlush;
          new_pc_d = excp_pc;
        end else if (any_req) begin
          state_d = StStall;
        end else begin
          state_d = StRun;
        end
      end
      StFlush: begin
        flush   = 1'b1;
        state_d = StDrain;
      end
      StDrain: state_d = StRun;
      default: state_d = StRun;
    endcase
    if (rst) stall = 6'b000000;
  end

  // Watchdog: counts consecutive STALL cycles, saturating at the limit.
  always_comb begin
    run_cnt_inc = (run_cnt_q == Limit) ? run_cnt_q : run_cnt_q + 16'd1;
    run_cnt_d   = run_cnt_q;
    tmo_d       = tmo_q;
    if (state_q == StStall) begin
      run_cnt_d = run_cnt_inc;
      if (run_cnt_inc == Limit) tmo_d = 1'b1;
    end
    if (state_d == StRun || state_d == StFlush) run_cnt_d = 16'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      new_pc_q  <= 32'd0;
      run_cnt_q <= 16'd0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_pc_q  <= new_pc_d;
      run_cnt_q <= run_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign new_pc        = new_pc_q;
  assign busy          = (state_q != StRun);
  assign stall_timeout = tmo_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (stall != 6'b000000) begin
      cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  assign stall_cycles = cyc_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// behavioural model of the control rules.
module tb_pipe_ctrl;

  localparam int unsigned Limit = 4;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic        excp_req = 1'b0;
  logic [31:0] excp_pc = 32'd0;
  logic [5:0]  stall;
  logic        flush, busy, stall_timeout;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;

  pipe_ctrl #(.STALL_LIMIT(Limit), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_req     (excp_req),
    .excp_pc      (excp_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .busy         (busy),
    .stall_timeout(stall_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_fl = cycles of flush/drain left (2 = flush cycle, 1 = drain cycle),
  // m_st = previous normal cycle held a request, m_run = consecutive held cycles.
  int          m_fl = 0;
  bit          m_st = 1'b0;
  int          m_run = 0;
  bit          m_tmo = 1'b0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_perf = 32'd0;

  function automatic logic [5:0] prio(input logic i, input logic e, input logic m);
    if (m) return 6'h1f;
    if (e) return 6'h0f;
    if (i) return 6'h07;
    return 6'h00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fl <= 0; m_st <= 1'b0; m_run <= 0; m_tmo <= 1'b0; m_pc <= 32'd0; m_perf <= 32'd0;
    end else if (m_fl == 2) begin
      m_fl <= 1;
    end else if (m_fl == 1) begin
      m_fl <= 0;
    end else begin
      if (prio(stallreq_id, stallreq_ex, stallreq_mem) != 6'h00) m_perf <= m_perf + 32'd1;
      if (m_st) begin
        m_run <= m_run + 1;
        if (m_run + 1 >= int'(Limit)) m_tmo <= 1'b1;
      end
      if (excp_req) begin
        m_fl <= 2; m_pc <= excp_pc; m_st <= 1'b0; m_run <= 0;
      end else if (stallreq_id | stallreq_ex | stallreq_mem) begin
        m_st <= 1'b1;
      end else begin
        m_st <= 1'b0; m_run <= 0;
      end
    end
  end

  task automatic compare();
    logic [5:0] es;
    es = (rst || m_fl != 0) ? 6'h00 : prio(stallreq_id, stallreq_ex, stallreq_mem);
    chk("stall", 64'(stall), 64'(es));
    chk("flush", 64'(flush), 64'(!rst && m_fl == 2));
    chk("new_pc", 64'(new_pc), 64'(m_pc));
    chk("busy", 64'(busy), 64'(!rst && (m_fl != 0 || m_st)));
    chk("stall_timeout", 64'(stall_timeout), 64'(m_tmo));
    chk("stall_cycles", 64'(stall_cycles), Perf ? 64'(m_perf) : 64'd0);
  endtask

  task automatic step(input logic r, input logic i, input logic e, input logic m,
                      input logic x, input logic [31:0] pc);
    @(negedge clk);
    rst = r; stallreq_id = i; stallreq_ex = e; stallreq_mem = m; excp_req = x; excp_pc = pc;
    #1;
    compare();
  endtask

  initial begin
    // Reset values
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_new_pc", 64'(new_pc), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    step(0, 0, 0, 0, 0, 0);

    // Priority
    step(0, 1, 0, 1, 0, 0);
    chk("prio_id_mem", 64'(stall), 64'h1f);
    step(0, 1, 0, 0, 0, 0);
    chk("prio_id_only", 64'(stall), 64'h07);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Exception during an ex stall, with masked re-requests in FLUSH and DRAIN
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 32'h0000_0180);
    chk("excp_n_stall", 64'(stall), 64'h0f);
    chk("excp_n_flush", 64'(flush), 64'h0);
    step(0, 0, 1, 0, 1, 32'hdead_beef);
    chk("excp_n1_flush", 64'(flush), 64'h1);
    chk("excp_n1_pc", 64'(new_pc), 64'h180);
    chk("excp_n1_stall", 64'(stall), 64'h0);
    step(0, 0, 1, 0, 1, 32'hdead_beef);
    chk("excp_n2_flush", 64'(flush), 64'h0);
    chk("excp_n2_stall", 64'(stall), 64'h0);
    chk("excp_n2_busy", 64'(busy), 64'h1);
    step(0, 0, 0, 0, 0, 0);
    chk("excp_n3_busy", 64'(busy), 64'h0);
    chk("excp_n3_flush", 64'(flush), 64'h0);
    chk("excp_n3_pc", 64'(new_pc), 64'h180);
    step(0, 0, 0, 0, 0, 0);

    // Watchdog with limit 4: cycle 1 is RUN, cycles 2..5 are the first four STALL cycles
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 0, 1, 0, 0);
      if (k == 5) chk("wdog_before", 64'(stall_timeout), 64'h0);
      if (k == 6) chk("wdog_set", 64'(stall_timeout), 64'h1);
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("wdog_sticky", 64'(stall_timeout), 64'h1);

    // Reset mid-STALL with ex request held
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("rst_mid_stall", 64'(stall), 64'h0);
    chk("rst_mid_busy", 64'(busy), 64'h0);
    chk("rst_mid_tmo", 64'(stall_timeout), 64'h0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("rst_release_stall", 64'(stall), 64'h0f);

    // Reset mid-FLUSH: no DRAIN afterwards
    step(0, 0, 0, 0, 1, 32'h40);
    step(0, 0, 0, 0, 0, 0);
    chk("flush_pre_rst", 64'(flush), 64'h1);
    step(1, 0, 0, 0, 0, 0);
    chk("flush_rst", 64'(flush), 64'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("flush_rst_nodrain", 64'(busy), 64'h0);

    // Perf counter: 10 stalled cycles interleaved with 5 free ones
    step(1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 15; j++) step(0, 0, (j % 3) != 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("perf_count", 64'(stall_cycles), Perf ? 64'd10 : 64'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. It sequences the stage registers (pc, if/id, id/ex, ex/mem, mem/wb) by turning per-stage stall requests into a hold vector. It converts exception requests into a one-cycle registered flush plus redirect PC. It also watches for runaway stalls and, optionally, counts stall cycles. It sits beside the datapath and drives the stall/flush inputs of every stage register.

## Interface

- STALL_LIMIT, default 255: consecutive stall cycles before the watchdog trips (1..65535).
- CNT_W, default 32: width of the stall performance counter.

- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stallreq_id  in  1  decode stage requests hold (load-use hazard).
- stallreq_ex  in  1  execute stage requests hold (multicycle mul/div).
- stallreq_mem  in  1  memory stage requests hold (bus wait).
- excp_req  in  1  exception/redirect request from the memory stage.
- excp_pc  in  32  handler address accompanying excp_req.
- stall  out  6  hold vector: bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 reserved (always 0).
- flush  out  1  clear all stage registers and load new_pc.
- new_pc  out  32  registered redirect address.
- busy  out  1  high whenever the FSM is not in RUN.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  count of cycles with stall != 0 (see Configuration).

## Operation

- **FSM states:** RUN, STALL, FLUSH, DRAIN; encoded in 2 bits; reset state RUN.
- **Stall vector:** combinational in RUN and STALL. The highest requesting stage wins.
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - none → 6'b000000
- In FLUSH and DRAIN, stall = 0 regardless of requests.
- **RUN:**
  - excp_req → FLUSH. excp_pc is captured into new_pc. excp_req has priority over stall requests.
  - Else any stallreq → STALL.
- **STALL:**
  - excp_req → FLUSH, with the same capture as in RUN.
  - No stallreq → RUN.
  - The run counter increments each cycle in STALL and saturates at STALL_LIMIT. When it reaches STALL_LIMIT, stall_timeout is set.
- **FLUSH:**
  - flush=1 for exactly one cycle; new_pc holds the captured value.
  - excp_req is ignored.
  - Always → DRAIN.
- **DRAIN:**
  - One cycle with all requests masked, because stage registers were just cleared and their requests are stale.
  - Always → RUN.
- **Run counter:** cleared on every entry to RUN or FLUSH; 16 bits wide.
- **stall_timeout:** cleared only by rst.
- **busy:** equals (state != RUN).

## Timing

- **Reset values:** rst asserted forces, immediately and asynchronously:
  - state=RUN, stall=0, flush=0, new_pc=0, busy=0, stall_timeout=0, stall_cycles=0.
  - stall is gated to 0 while rst is high.
- **Stall latency:** 0 cycles; stall follows stallreq_* in the same cycle (RUN/STALL only).
- **Exception timing:**
  - excp_req sampled high at edge N → flush=1 and new_pc=excp_pc during cycle N+1.
  - DRAIN occupies cycle N+2.
  - RUN resumes at cycle N+3.
  - A minimum of 3 cycles separates two accepted exceptions.
- **Exception with stall:** in the excp_req cycle itself, stall reflects the stall requests normally.
- **Watchdog timing:** with a continuous stall from cycle 1, stall_timeout rises at the edge ending the STALL_LIMIT-th STALL cycle.
- **Reset mid-FLUSH:** flush drops immediately; no DRAIN follows.

## Configuration

- **PIPE_CTRL_PERF_EN defined:**
  - stall_cycles increments on every clock where stall != 0.
  - It wraps modulo 2^CNT_W and is reset only by rst.
- **Not defined:**
  - The counter logic is omitted.
  - stall_cycles is tied to 0.
- All other behaviour is identical in both builds.

## Test plan

- **Reset:**
  - Stimulus: assert rst mid-STALL with stallreq_ex=1.
  - Response: stall=0, busy=0, flush=0 while rst is high. After release with stallreq_ex still 1, stall=6'b001111 in the first cycle.
- **Priority:**
  - Stimulus: stallreq_id=1, stallreq_mem=1 in the same cycle.
  - Response: stall=6'b011111. Dropping mem leaves 6'b000111 in the same cycle.
- **Exception:**
  - Stimulus: excp_req=1, excp_pc=32'h0000_0180 for one cycle N, during an active ex stall.
  - Response:
    - Cycle N: stall=6'b001111.
    - N+1: flush=1, new_pc=32'h180, stall=0.
    - N+2: flush=0, stall=0 (DRAIN).
    - N+3: RUN.
- **Masking:**
  - Stimulus: second excp_req pulses in FLUSH and DRAIN.
  - Response: no second flush; new_pc unchanged.
- **Watchdog:**
  - Stimulus: STALL_LIMIT=4, stallreq_mem held 6 cycles.
  - Response: stall_timeout=1 after the 4th stall cycle, and it stays 1 after the request drops.
- **Perf counter (PIPE_CTRL_PERF_EN):**
  - Stimulus: 10 stalled cycles interleaved with 5 free cycles.
  - Response: stall_cycles=10. Without the macro, stall_cycles=0 throughout.
